// File: rtl/serial_pkg.sv
// Shared definitions for the serial receive buffer: handshake FSM states,
// status bit positions and a saturating increment helper.
package serial_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      STROBE  = 2'd1,
      CAPTURE = 2'd2,
      RELEASE = 2'd3
   } rx_state_t;

   localparam int ST_AVAIL = 1;
   localparam int ST_FULL  = 2;
   localparam int ST_FLAG  = 3;

   function automatic logic [7:0] sat_inc8(input logic [7:0] val);
      return (val == 8'hFF) ? val : val + 8'd1;
   endfunction

endpackage

// File: rtl/serial_rx_buffer_sync_fifo.sv
// sync_fifo: single-clock first-word fall-through FIFO with occupancy count.
// The head is read asynchronously so it is visible the cycle after a push; 0 when empty.
module sync_fifo #(
   parameter int DEPTH  = 16,
   parameter int DATA_W = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wr_en,
   input  logic [DATA_W-1:0]        wr_data,
   input  logic                     rd_en,
   output logic [DATA_W-1:0]        rd_data,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     full,
   output logic                     empty
);

   localparam int ADDR_W = $clog2(DEPTH);
   localparam int LVL_W  = ADDR_W + 1;
   localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [ADDR_W-1:0] wr_ptr_reg;
   logic [ADDR_W-1:0] rd_ptr_reg;
   logic [LVL_W-1:0]  level_reg;
   logic              rd_ok;
   logic              wr_ok;

   assign empty = (level_reg == '0);
   assign full  = (level_reg == FULL_LVL);
   assign level = level_reg;

   // A write into a full FIFO is accepted only when a pop frees the slot in the same cycle.
   assign rd_ok = rd_en && !empty;
   assign wr_ok = wr_en && (!full || rd_ok);

   always_ff @(posedge clk) begin
      if (wr_ok) begin
         mem[wr_ptr_reg] <= wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         level_reg  <= '0;
      end else begin
         if (wr_ok) begin
            wr_ptr_reg <= wr_ptr_reg + ADDR_W'(1);
         end
         if (rd_ok) begin
            rd_ptr_reg <= rd_ptr_reg + ADDR_W'(1);
         end
         case ({wr_ok, rd_ok})
            2'b10:   level_reg <= level_reg + LVL_W'(1);
            2'b01:   level_reg <= level_reg - LVL_W'(1);
            default: level_reg <= level_reg;
         endcase
      end
   end

   assign rd_data = empty ? '0 : mem[rd_ptr_reg];

endmodule

// File: rtl/serial_rx_buffer.sv
// serial_rx_buffer: drains bytes from the UART via its rdn/data_ready handshake into a FIFO
// and exposes head byte and status to the CPU. Define RX_OVF_CNT_EN to enable the drop counter.
module serial_rx_buffer
   import serial_pkg::*;
#(
   parameter int DEPTH  = 16,
   parameter int DATA_W = 8,
   parameter int CNT_W  = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     uart_ready,
   input  logic [DATA_W-1:0]        uart_data,
   input  logic                     uart_err,
   output logic                     uart_rdn,
   output logic [DATA_W-1:0]        cpu_rd_data,
   input  logic                     cpu_pop,
   input  logic                     cpu_clr,
   output logic [3:0]               status,
   output logic [$clog2(DEPTH):0]   level,
   output logic [CNT_W-1:0]         ovf_count
);

   rx_state_t         state_reg;
   rx_state_t         state_next;
   logic              rdn_reg;
   logic              push_req_reg;
   logic [DATA_W-1:0] cap_data_reg;
   logic              cap_err_reg;
   logic              ovf_reg;
   logic              err_reg;
   logic              fifo_full;
   logic              fifo_empty;
   logic              pop_ok;
   logic              err_drop;
   logic              ovf_drop;
   logic              drop;

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (uart_ready) state_next = STROBE;
         STROBE:  state_next = CAPTURE;
         CAPTURE: state_next = RELEASE;
         // Holding here until data_ready falls keeps one pending byte from being read twice.
         RELEASE: if (!uart_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg    <= IDLE;
         rdn_reg      <= 1'b1;
         push_req_reg <= 1'b0;
         cap_data_reg <= '0;
         cap_err_reg  <= 1'b0;
      end else begin
         state_reg    <= state_next;
         rdn_reg      <= !((state_next == STROBE) || (state_next == CAPTURE));
         push_req_reg <= (state_reg == CAPTURE);
         if (state_reg == CAPTURE) begin
            cap_data_reg <= uart_data;
            cap_err_reg  <= uart_err;
         end
      end
   end

   assign uart_rdn = rdn_reg;

   assign pop_ok   = cpu_pop && !fifo_empty;
   assign err_drop = push_req_reg && cap_err_reg;
   assign ovf_drop = push_req_reg && !cap_err_reg && fifo_full && !pop_ok;
   assign drop     = err_drop || ovf_drop;

   sync_fifo #(
      .DEPTH  (DEPTH),
      .DATA_W (DATA_W)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (push_req_reg && !cap_err_reg),
      .wr_data (cap_data_reg),
      .rd_en   (cpu_pop),
      .rd_data (cpu_rd_data),
      .level   (level),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   // A drop in the same cycle as cpu_clr leaves the flag set.
   always_ff @(posedge clk) begin
      if (rst) begin
         ovf_reg <= 1'b0;
         err_reg <= 1'b0;
      end else begin
         if (ovf_drop)     ovf_reg <= 1'b1;
         else if (cpu_clr) ovf_reg <= 1'b0;
         if (err_drop)     err_reg <= 1'b1;
         else if (cpu_clr) err_reg <= 1'b0;
      end
   end

`ifdef RX_OVF_CNT_EN
   logic [CNT_W-1:0] cnt_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_reg <= '0;
      end else if (cpu_clr) begin
         cnt_reg <= drop ? CNT_W'(1) : '0;
      end else if (drop && (cnt_reg != '1)) begin
         cnt_reg <= cnt_reg + CNT_W'(1);
      end
   end

   assign ovf_count = cnt_reg;
`else
   assign ovf_count = '0;
`endif

   always_comb begin
      status           = 4'b0000;
      status[ST_AVAIL] = !fifo_empty;
      status[ST_FULL]  = fifo_full;
      status[ST_FLAG]  = ovf_reg || err_reg;
   end

endmodule
